// File: rtl/br_resolve_queue_if.sv
// Fetch/EX-side bundle for the branch resolve queue. When BR_STATS_EN is defined,
// the bundle also carries the statistics counters.
interface br_resolve_queue_if #(
  parameter int IDX_W = 2,
  parameter int W     = 32
);
  logic             push_en;
  logic [W-1:0]     push_pc;
  logic [IDX_W-1:0] push_index;
  logic             push_predict;
  logic [W-1:0]     push_target;
  logic             full;
  logic             empty;
  logic             res_valid;
  logic             res_taken;
  logic [W-1:0]     res_target;
  logic             squash;
  logic             upd_br;
  logic             upd_taken;
  logic [IDX_W-1:0] upd_index;
  logic [W-1:0]     upd_target;
  logic             mispredict;
  logic [W-1:0]     redirect_pc;
  logic             err;
`ifdef BR_STATS_EN
  logic [15:0]      stat_branches;
  logic [15:0]      stat_mispredicts;
`endif

  modport master (
    output push_en, push_pc, push_index, push_predict, push_target,
    output res_valid, res_taken, res_target, squash,
    input  full, empty, upd_br, upd_taken, upd_index, upd_target,
    input  mispredict, redirect_pc, err
`ifdef BR_STATS_EN
    , input stat_branches, stat_mispredicts
`endif
  );

  modport slave (
    input  push_en, push_pc, push_index, push_predict, push_target,
    input  res_valid, res_taken, res_target, squash,
    output full, empty, upd_br, upd_taken, upd_index, upd_target,
    output mispredict, redirect_pc, err
`ifdef BR_STATS_EN
    , output stat_branches, stat_mispredicts
`endif
  );
endinterface

// File: rtl/br_resolve_queue.sv
// In-order queue of in-flight branch predictions; resolves the oldest entry at EX,
// drives the predictor update and the mispredict redirect. BR_STATS_EN adds counters.
module br_resolve_queue #(
  parameter int DEPTH = 4,
  parameter int IDX_W = 2,
  parameter int W     = 32
) (
  input logic              CLK,
  input logic              nRST,
  br_resolve_queue_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [W-1:0]     r_pc   [DEPTH];
  logic [IDX_W-1:0] r_idx  [DEPTH];
  logic             r_pred [DEPTH];
  logic [W-1:0]     r_tgt  [DEPTH];

  logic [PW-1:0]    r_head, r_tail;
  logic [CW-1:0]    r_count;
  logic             r_upd_br, r_upd_taken, r_mis, r_err;
  logic [IDX_W-1:0] r_upd_index;
  logic [W-1:0]     r_upd_target, r_redirect;

  logic             w_full, w_empty, w_pop, w_push, w_mis, w_err_ev;
  logic [W-1:0]     w_redirect;

  assign w_full    = (r_count == CW'(DEPTH));
  assign w_empty   = (r_count == {CW{1'b0}});
  assign bus.full  = w_full;
  assign bus.empty = w_empty;

  // Pop/push qualification, outcome evaluation and protocol-error detection
  always_comb begin
    w_pop      = 1'b0;
    w_push     = 1'b0;
    w_mis      = 1'b0;
    w_err_ev   = 1'b0;
    w_redirect = {W{1'b0}};
    if (bus.squash) begin
      w_pop  = 1'b0;
      w_push = 1'b0;
    end else begin
      w_pop = bus.res_valid && !w_empty;
      if (w_pop) begin
        case ({r_pred[r_head], bus.res_taken})
          2'b10: begin
            w_mis      = 1'b1;
            w_redirect = r_pc[r_head] + W'(4);
          end
          2'b01: begin
            w_mis      = 1'b1;
            w_redirect = bus.res_target;
          end
          2'b11: begin
            if (r_tgt[r_head] != bus.res_target) begin
              w_mis      = 1'b1;
              w_redirect = bus.res_target;
            end else begin
              w_mis      = 1'b0;
            end
          end
          default: w_mis = 1'b0;
        endcase
      end else begin
        w_mis = 1'b0;
      end
      // A mispredict discards the wrong path, including anything fetched this cycle
      w_push   = bus.push_en && (!w_full || w_pop) && !w_mis;
      w_err_ev = (bus.res_valid && w_empty) || (bus.push_en && w_full && !w_pop);
    end
  end

  // Pointer and occupancy state
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_head  <= {PW{1'b0}};
      r_tail  <= {PW{1'b0}};
      r_count <= {CW{1'b0}};
    end else if (bus.squash || w_mis) begin
      r_head  <= r_tail;
      r_count <= {CW{1'b0}};
    end else begin
      if (w_push) r_tail <= r_tail + PW'(1);
      if (w_pop)  r_head <= r_head + PW'(1);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  // Entry storage; contents are only meaningful between head and tail
  always_ff @(posedge CLK) begin
    if (w_push) begin
      r_pc[r_tail]   <= bus.push_pc;
      r_idx[r_tail]  <= bus.push_index;
      r_pred[r_tail] <= bus.push_predict;
      r_tgt[r_tail]  <= bus.push_target;
    end
  end

  // Registered predictor update, redirect and sticky error
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_upd_br     <= 1'b0;
      r_upd_taken  <= 1'b0;
      r_upd_index  <= {IDX_W{1'b0}};
      r_upd_target <= {W{1'b0}};
      r_mis        <= 1'b0;
      r_redirect   <= {W{1'b0}};
      r_err        <= 1'b0;
    end else begin
      r_upd_br     <= w_pop;
      r_upd_taken  <= w_pop && bus.res_taken;
      r_upd_index  <= w_pop ? r_idx[r_head] : {IDX_W{1'b0}};
      r_upd_target <= w_pop ? bus.res_target : {W{1'b0}};
      r_mis        <= w_mis;
      r_redirect   <= w_redirect;
      r_err        <= r_err || w_err_ev;
    end
  end

  assign bus.upd_br      = r_upd_br;
  assign bus.upd_taken   = r_upd_taken;
  assign bus.upd_index   = r_upd_index;
  assign bus.upd_target  = r_upd_target;
  assign bus.mispredict  = r_mis;
  assign bus.redirect_pc = r_redirect;
  assign bus.err         = r_err;

`ifdef BR_STATS_EN
  logic [15:0] r_stat_br, r_stat_mis;

  // Saturating statistics; squash deliberately leaves them alone
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_stat_br  <= 16'h0000;
      r_stat_mis <= 16'h0000;
    end else begin
      if (w_pop && (r_stat_br != 16'hFFFF)) r_stat_br <= r_stat_br + 16'h0001;
      if (w_mis && (r_stat_mis != 16'hFFFF)) r_stat_mis <= r_stat_mis + 16'h0001;
    end
  end

  assign bus.stat_branches    = r_stat_br;
  assign bus.stat_mispredicts = r_stat_mis;
`endif
endmodule

// File: doc/br_resolve_queue.md
Name: br_resolve_queue

Overview:
In-order tracking queue for in-flight branch predictions. It sits downstream of the 4-entry 2-bit branch predictor.
- At fetch, it records each predicted branch: PC, predictor index, prediction, predicted target.
- At EX resolution, it pops the oldest entry and compares it with the actual outcome.
- It issues the predictor table-update pulse (br / br_taken / index_update / br_target_I).
- On a misprediction, it issues a flush plus redirect PC to fetch.

Parameters:
DEPTH, 4, number of queue entries; must be a power of 2, minimum 2.
IDX_W, 2, predictor index width; must match the predictor table (4 entries).
W, 32, PC/target width.

Ports:
CLK  input  1  clock
nRST  input  1  asynchronous active-low reset
push_en  input  1  fetch: record a branch prediction this cycle
push_pc  input  W  PC of the fetched branch
push_index  input  IDX_W  predictor index used at fetch
push_predict  input  1  predictor output (1 = taken)
push_target  input  W  predictor target
full  output  1  queue full; fetch must stall further branch fetch
empty  output  1  queue empty
res_valid  input  1  EX: oldest branch resolved this cycle
res_taken  input  1  actual direction
res_target  input  W  actual target
squash  input  1  external flush (exception/jump); clears the queue
upd_br  output  1  predictor update strobe (to bpif.br)
upd_taken  output  1  to bpif.br_taken
upd_index  output  IDX_W  to bpif.index_update
upd_target  output  W  to bpif.br_target_I
mispredict  output  1  one-cycle flush pulse to IF/ID
redirect_pc  output  W  correct fetch PC, valid while mispredict=1
err  output  1  sticky protocol error

Behaviour:
- Reset (async, nRST=0):
  - Pointers and count = 0; full=0, empty=1.
  - upd_br=0, upd_taken=0, upd_index=0, upd_target=0.
  - mispredict=0, redirect_pc=0, err=0.
  - Reset mid-operation discards all entries immediately.
- Storage: circular buffer, head/tail pointers of log2(DEPTH) bits that wrap modulo DEPTH, plus a count of log2(DEPTH)+1 bits.
- full = (count==DEPTH); empty = (count==0). Both are combinational from registered state.
- Push: when push_en=1 and not full, write the entry at tail and advance tail.
- Pop: when res_valid=1 and not empty, read the head entry, advance head, and evaluate the outcome.
- Simultaneous push + pop with no mispredict: both performed, count unchanged. This is allowed even when full.
- Outcome evaluation (head entry predict p, target t, pc; actual taken a, target r):
  - p=1, a=0: mispredict, redirect = pc+4.
  - p=0, a=1: mispredict, redirect = r.
  - p=1, a=1, t != r: mispredict, redirect = r.
  - Otherwise: correct prediction.
  - pc+4 is computed modulo 2^W.
- Outputs are registered with one-cycle latency after res_valid:
  - upd_br pulses 1 for exactly one cycle with upd_taken=a, upd_index=entry index, upd_target=r.
  - This update occurs on every valid pop, correct or not.
- On mispredict:
  - mispredict pulses 1 and redirect_pc holds the correct PC for that cycle.
  - All remaining (younger, wrong-path) entries are discarded: count=0, head=tail.
  - A push in the same cycle is dropped.
- squash=1:
  - Clears the queue the same edge; any push that cycle is dropped.
  - A res_valid in the same cycle is ignored (no update, no mispredict).
  - squash has priority over everything except reset.
- Errors (err set and held until reset):
  - res_valid while empty: no update, no mispredict.
  - push_en while full without a simultaneous pop: push dropped.
- upd_br, mispredict and redirect_pc are 0 in every cycle without a valid pop.

Optional Feature:
Macro BR_STATS_EN.
- Defined: adds outputs stat_branches[15:0] and stat_mispredicts[15:0]. Each is a saturating counter (holds at 16'hFFFF), incremented on every valid pop / every mispredict respectively. Both reset to 0 and are unaffected by squash.
- Undefined: ports and counters absent; behaviour otherwise identical.

Test Plan:
1. Reset, then push pc=0x100, idx=1, predict=0, target=0. Next cycle res_valid, taken=0, target=0x200 -> one cycle later upd_br=1, upd_taken=0, upd_index=1, upd_target=0x200, mispredict=0, empty=1.
2. Push pc=0x40, predict=1, target=0x80. Resolve taken=0 -> mispredict=1, redirect_pc=0x44, upd_taken=0.
3. Push pc=0x40, predict=1, target=0x80. Resolve taken=1, target=0x90 -> mispredict=1, redirect_pc=0x90.
4. Push 4 entries -> full=1; 5th push alone -> dropped, err=1. Push+pop in the same cycle while full -> both accepted, full stays 1.
5. Three queued entries; the oldest mispredicts while a push is asserted -> queue empty afterwards, push dropped, only one upd_br pulse.
6. Two queued entries; squash with simultaneous res_valid -> empty=1, no upd_br, no mispredict. res_valid next cycle -> err=1.
